// File: rtl/fetch_bundle_queue.sv
// Decode-side circular FIFO for 4-wide fetch bundles with first-word fall-through head,
// skid-based fetch back-pressure, sticky overflow flag and ROB-mispredict flush.
module fetch_bundle_queue #(
  parameter int DEPTH = 4,
  parameter int SKID  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           fetch_valid,
  input  logic [63:0]                    pc_in,
  input  logic [63:0]                    inst_in,
  input  logic [63:0]                    recv_pc_in,
  input  logic [3:0]                     pred_in,
  input  logic                           has_mispredict,
  input  logic                           dec_ready,
  output logic                           stall_fetch,
  output logic                           dec_valid,
  output logic [63:0]                    pc_to_dec,
  output logic [63:0]                    inst_to_dec,
  output logic [63:0]                    recv_pc_to_dec,
  output logic [3:0]                     pred_result_to_dec,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 196;
  localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH_C = CW'(DEPTH - SKID);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, enq, deq;
  logic [EW-1:0] wr_entry, head_entry;

  assign full     = (count_q == FULL_C);
  assign deq      = dec_valid & dec_ready & ~has_mispredict;
  // A full queue still accepts when the head leaves in the same cycle.
  assign enq      = fetch_valid & ~has_mispredict & (~full | deq);
  assign wr_entry = {pred_in, recv_pc_in, inst_in, pc_in};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (fetch_valid & full & ~deq & ~has_mispredict);
    if (has_mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (!enq && deq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is reset so the head outputs read zero out of reset; flush leaves data intact.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (enq && (wr_ptr_q == PW'(gi))) begin
          mem_q[gi] <= wr_entry;
        end
      end
    end
  endgenerate

  assign head_entry         = mem_q[rd_ptr_q];
  assign pc_to_dec          = head_entry[63:0];
  assign inst_to_dec        = head_entry[127:64];
  assign recv_pc_to_dec     = head_entry[191:128];
  assign pred_result_to_dec = head_entry[195:192];

  assign dec_valid    = (count_q != '0);
  assign stall_fetch  = (count_q >= STALL_TH_C);
  assign occupancy    = count_q;
  assign overflow_err = overflow_q;

endmodule
